// File: rtl/div_post.sv
// div_post: output stage of the pipelined restoring divider.
// Carries each operation's valid/sign/exception sideband alongside the slice
// chain, then applies the signed fix-up and divide-by-zero override to the
// unsigned quotient/remainder coming out of the last slice.

package div_post_pkg;
    // Per-operation sideband that travels with the operands through the chain.
    typedef struct packed {
        logic neg_q;   // negate quotient (operand signs differ)
        logic neg_r;   // negate remainder (dividend negative)
        logic div0;    // divisor was zero
        logic ovf;     // most-negative / -1
    } flags_t;
endpackage

// One delay-line stage: matches one div_slice register of the chain.
module div_post_stage
    import div_post_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   vld_d,
    input  flags_t flg_d,
    output logic   vld_q,
    output flags_t flg_q
);

    // Shift valid and flags one slot; only valid needs clearing, flags are
    // don't-care whenever valid is low, but clearing both keeps state tidy.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            flg_q <= '0;
        end else begin
            vld_q <= vld_d;
            flg_q <= flg_d;
        end
    end

endmodule

module div_post
    import div_post_pkg::*;
#(
    parameter int N   = 32,
    parameter int LAT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic                       neg_q_i,
    input  logic                       neg_r_i,
    input  logic                       div0_i,
    input  logic                       ovf_i,
    input  logic [N-1:0]               quotient_i,
    input  logic [N-1:0]               remainder_i,
    output logic                       valid_o,
    output logic [N-1:0]               quotient_o,
    output logic [N-1:0]               remainder_o,
    output logic                       div0_o,
    output logic                       ovf_o,
    output logic                       busy_o,
    output logic [$clog2(LAT+2)-1:0]   inflight_o
);

    localparam int CW = $clog2(LAT+2);

    // vld_pipe[0]/flg_pipe[0] are the live inputs; [LAT] is the tail that
    // lines up with quotient_i/remainder_i of the same operation.
    logic   vld_pipe [LAT:0];
    flags_t flg_pipe [LAT:0];

    logic   tail_vld;
    flags_t tail_flg;
    logic [N-1:0] q_fix;
    logic [N-1:0] r_fix;

    assign vld_pipe[0] = in_valid_i;
    assign flg_pipe[0] = '{neg_q: neg_q_i, neg_r: neg_r_i, div0: div0_i, ovf: ovf_i};

    // No stall anywhere in the divider, so the line simply shifts every cycle.
    for (genvar i = 0; i < LAT; i++) begin : g_dly
        div_post_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .vld_d (vld_pipe[i]),
            .flg_d (flg_pipe[i]),
            .vld_q (vld_pipe[i+1]),
            .flg_q (flg_pipe[i+1])
        );
    end

    assign tail_vld = vld_pipe[LAT];
    assign tail_flg = flg_pipe[LAT];

    // Signed correction. Divide-by-zero wins over negation; overflow needs no
    // override since negating 2^(N-1) mod 2^N already yields the most negative
    // value. A zero divisor leaves the dividend magnitude as remainder, so the
    // neg_r fix-up restores the original dividend for that case too.
    always_comb begin
        q_fix = quotient_i;
        if (tail_flg.div0)
            q_fix = '1;
        else if (tail_flg.neg_q)
            q_fix = -quotient_i;
        r_fix = tail_flg.neg_r ? -remainder_i : remainder_i;
    end

    // Result register: strobe every cycle, data only updates on a valid tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div0_o      <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            valid_o <= tail_vld;
            div0_o  <= tail_vld & tail_flg.div0;
            ovf_o   <= tail_vld & tail_flg.ovf;
            if (tail_vld) begin
                quotient_o  <= q_fix;
                remainder_o <= r_fix;
            end
        end
    end

    // In-flight count: +1 on accept, -1 on result strobe, net zero on both.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_o <= '0;
        end else begin
            case ({in_valid_i, valid_o})
                2'b10:   inflight_o <= inflight_o + CW'(1);
                2'b01:   inflight_o <= inflight_o - CW'(1);
                default: inflight_o <= inflight_o;
            endcase
        end
    end

    assign busy_o = (inflight_o != '0);

endmodule

// File: tb/tb_div_post.sv
// tb_div_post: random + directed bench for div_post. The bench plays the role
// of the slice chain (presents magnitudes exactly LAT cycles after issue) and
// predicts final results straight from the signed/unsigned operand values.
module tb_div_post;

    localparam int N     = 32;
    localparam int LAT   = 32;
    localparam int CW    = $clog2(LAT+2);
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid_i, neg_q_i, neg_r_i, div0_i, ovf_i;
    logic [N-1:0]  quotient_i, remainder_i;
    logic          valid_o, div0_o, ovf_o, busy_o;
    logic [N-1:0]  quotient_o, remainder_o;
    logic [CW-1:0] inflight_o;

    always #5 clk = ~clk;

    div_post #(.N(N), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .neg_q_i     (neg_q_i),
        .neg_r_i     (neg_r_i),
        .div0_i      (div0_i),
        .ovf_i       (ovf_i),
        .quotient_i  (quotient_i),
        .remainder_i (remainder_i),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div0_o      (div0_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o),
        .inflight_o  (inflight_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int peak     = 0;

    // Per-cycle model state, indexed by absolute cycle number.
    logic         sl_vld [DEPTH];
    logic [N-1:0] sl_q   [DEPTH];
    logic [N-1:0] sl_r   [DEPTH];
    logic         ex_vld [DEPTH];
    logic [N-1:0] ex_q   [DEPTH];
    logic [N-1:0] ex_r   [DEPTH];
    logic         ex_d0  [DEPTH];
    logic         ex_ov  [DEPTH];
    int           iss    [DEPTH];
    logic [N-1:0] hold_q, hold_r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs produced by the previous edge, then drive.
    task automatic step(input logic r, input logic iv, input logic sgn,
                        input logic [N-1:0] a, input logic [N-1:0] b);
        int           exp_inf;
        logic         neg_a, neg_b, d0, ov, nq, nr;
        logic [N-1:0] ma, mb, sq, sr, eq, er;
        @(negedge clk);
        if (cyc > 0) begin
            exp_inf = 0;
            for (int t = cyc - LAT - 1; t < cyc; t++)
                if (t >= 0) exp_inf += iss[t];
            chk("valid", valid_o, ex_vld[cyc]);
            if (ex_vld[cyc]) begin
                hold_q = ex_q[cyc];
                hold_r = ex_r[cyc];
            end
            chk("quot", quotient_o, hold_q);
            chk("rem", remainder_o, hold_r);
            chk("div0", div0_o, ex_vld[cyc] & ex_d0[cyc]);
            chk("ovf", ovf_o, ex_vld[cyc] & ex_ov[cyc]);
            chk("inflight", inflight_o, exp_inf);
            chk("busy", busy_o, exp_inf != 0);
            chk("infl_max", inflight_o <= LAT + 1, 1'b1);
            if (int'(inflight_o) > peak) peak = int'(inflight_o);
        end

        // Operand-level view of the op.
        neg_a = sgn & a[N-1];
        neg_b = sgn & b[N-1];
        ma    = neg_a ? -a : a;
        mb    = neg_b ? -b : b;
        d0    = (b == '0);
        ov    = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        nq    = (neg_a ^ neg_b) && !d0;
        nr    = neg_a;
        // What the slice chain would emit (quotient is don't-care on div0).
        if (d0) begin
            sq = $urandom();
            sr = ma;
        end else begin
            sq = ma / mb;
            sr = ma % mb;
        end
        // Architectural result straight from the operands.
        if (d0) begin
            eq = '1;
            er = a;
        end else if (ov) begin
            eq = 32'h8000_0000;
            er = '0;
        end else if (sgn) begin
            eq = $signed(a) / $signed(b);
            er = $signed(a) % $signed(b);
        end else begin
            eq = a / b;
            er = a % b;
        end

        rst        = r;
        in_valid_i = iv;
        neg_q_i    = iv ? nq : 1'($urandom());
        neg_r_i    = iv ? nr : 1'($urandom());
        div0_i     = iv ? d0 : 1'($urandom());
        ovf_i      = iv ? ov : 1'($urandom());
        quotient_i  = sl_vld[cyc] ? sl_q[cyc] : $urandom();
        remainder_i = sl_vld[cyc] ? sl_r[cyc] : $urandom();

        if (r) begin
            for (int t = 0; t <= cyc; t++) iss[t] = 0;
            for (int t = cyc + 1; t < DEPTH; t++) begin
                sl_vld[t] = 1'b0;
                ex_vld[t] = 1'b0;
            end
            hold_q = '0;
            hold_r = '0;
        end else if (iv && (cyc + LAT + 1 < DEPTH)) begin
            iss[cyc]           = 1;
            sl_vld[cyc+LAT]    = 1'b1;
            sl_q[cyc+LAT]      = sq;
            sl_r[cyc+LAT]      = sr;
            ex_vld[cyc+LAT+1]  = 1'b1;
            ex_q[cyc+LAT+1]    = eq;
            ex_r[cyc+LAT+1]    = er;
            ex_d0[cyc+LAT+1]   = d0;
            ex_ov[cyc+LAT+1]   = ov;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom(), $urandom());
    endtask

    task automatic rnd_op(output logic sgn, output logic [N-1:0] a, output logic [N-1:0] b);
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom();
        case ($urandom_range(0, 9))
            0:       b = '0;
            1:       begin sgn = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       b = $urandom_range(1, 15);
            3:       b = -($urandom_range(1, 9));
            default: b = $urandom() >> $urandom_range(0, 31);
        endcase
    endtask

    initial begin
        logic         s;
        logic [N-1:0] a, b;
        for (int t = 0; t < DEPTH; t++) begin
            sl_vld[t] = 1'b0; ex_vld[t] = 1'b0; iss[t] = 0;
            sl_q[t] = '0; sl_r[t] = '0; ex_q[t] = '0; ex_r[t] = '0;
            ex_d0[t] = 1'b0; ex_ov[t] = 1'b0;
        end
        hold_q = '0; hold_r = '0;
        rst = 1'b1; in_valid_i = 1'b0; neg_q_i = 1'b0; neg_r_i = 1'b0;
        div0_i = 1'b0; ovf_i = 1'b0; quotient_i = '0; remainder_i = '0;

        // Reset, then idle cycles checking reset state.
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Directed cases, issued back to back.
        step(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);                 // 14 r 2
        step(1'b0, 1'b1, 1'b1, -32'sd7, 32'd2);                 // -3 r -1
        step(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);                   // div0, r=5
        step(1'b0, 1'b1, 1'b1, -32'sd5, 32'd0);                 // div0, r=-5
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   // ovf
        idle(LAT + 4);

        // 40-op continuous stream; counter must peak at LAT+1 and drain.
        peak = 0;
        for (int i = 0; i < 40; i++) begin
            rnd_op(s, a, b);
            step(1'b0, 1'b1, s, a, b);
        end
        idle(LAT + 4);
        chk("peak", peak, LAT + 1);

        // Reset mid-flight: 5 ops, reset at local cycle 10 with a colliding issue.
        for (int i = 0; i < 5; i++) begin
            rnd_op(s, a, b);
            step(1'b0, 1'b1, s, a, b);
        end
        idle(5);
        step(1'b1, 1'b1, 1'b0, 32'd9, 32'd3);
        idle(LAT + 8);
        step(1'b0, 1'b1, 1'b1, -32'sd100, 32'd7);
        idle(LAT + 4);

        // Random issue with gaps.
        for (int i = 0; i < 80; i++) begin
            rnd_op(s, a, b);
            step(1'b0, 1'($urandom_range(0, 2) != 0), s, a, b);
        end
        idle(LAT + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
